// File: rtl/bus_slave_responder_if.sv
// Bus bundle between an initiator and the slave responder.
// The master drives the request side and the slave drives the response side.
interface bus_slave_responder_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              i_sel;
  logic              i_write;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              o_ok;
  logic [DATA_W-1:0] o_rdata;
  logic              o_busy;
  logic [1:0]        o_state;

  modport master (
    output i_sel, i_write, i_addr, i_wdata,
    input  o_ok, o_rdata, o_busy, o_state
  );

  modport slave (
    input  i_sel, i_write, i_addr, i_wdata,
    output o_ok, o_rdata, o_busy, o_state
  );
endinterface

// File: rtl/bus_slave_responder.sv
// Target-side responder for the select/write/ok bus.
// A request is accepted in IDLE, held for WAIT_CYCLES+1 wait cycles, and then
// answered with a one-cycle ok. Reads return data from a small register file.
// Writes commit to the register file as the block leaves RESP.
module bus_slave_responder #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2   // legal range 0..15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  bus_slave_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ok_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we_d;

  // A latched write lands in the register file on the RESP->IDLE edge
  assign mem_we_d = (state_q == RESP) && write_q;

  // Transfer FSM. ok/busy are registered so that they track the state register exactly
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ok_q   <= 1'b0;
          busy_q <= bus.i_sel;
          if (bus.i_sel) begin
            write_q <= bus.i_write;
            addr_q  <= bus.i_addr;
            wdata_q <= bus.i_wdata;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          busy_q <= 1'b1;
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= RESP;
            ok_q    <= 1'b1;
            if (!write_q) begin
              rdata_q <= mem_q[addr_q];
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          ok_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ok_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Register file. Each entry is cleared on reset and written by a committing write
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    // Entry gi takes the latched write data when the committing write targets it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        mem_q[gi] <= '0;
      end else if (mem_we_d && (addr_q == ADDR_W'(gi))) begin
        mem_q[gi] <= wdata_q;
      end
    end
  end

  assign bus.o_ok    = ok_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_rdata = rdata_q;
  assign bus.o_state = state_q;

endmodule

// File: tb/tb_bus_slave_responder.sv
// Bench for bus_slave_responder.
// Two instances are built: one with WAIT_CYCLES=2 and one with WAIT_CYCLES=0.
// Each instance has a transfer-timeline model that is compared on every cycle.
// Directed transfers add literal expectations.
module tb_bus_slave_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel, wr;
  logic [2:0] addr;
  logic [7:0] wdata;
  int         act;          // 0/1 selects a single DUT, 2 drives both
  int         cyc = 0;
  int         pass_cnt = 0;
  int         chk_cnt = 0;

  logic [1:0]      ok_w, busy_w;
  logic [1:0][1:0] st_w;
  logic [1:0][7:0] rd_w;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 2 : 0;

    bus_slave_responder_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    assign bus.i_sel   = (act == gi || act == 2) ? sel : 1'b0;
    assign bus.i_write = wr;
    assign bus.i_addr  = addr;
    assign bus.i_wdata = wdata;

    bus_slave_responder #(.ADDR_W(3), .DATA_W(8), .WAIT_CYCLES(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
    );

    assign ok_w[gi]   = bus.o_ok;
    assign busy_w[gi] = bus.o_busy;
    assign st_w[gi]   = bus.o_state;
    assign rd_w[gi]   = bus.o_rdata;

    // Model: a transfer accepted at edge S is waiting after edges S..S+W,
    // responding after edge S+W+1, and idle again after edge S+W+2.
    int         n;
    int         start;
    bit         t_wr;
    logic [2:0] t_a;
    logic [7:0] t_d;
    logic [7:0] mmem [8];
    logic [7:0] exp_rd;
    int         ok_cnt;

    initial begin : model
      n = 0; start = -100; exp_rd = '0; t_wr = 1'b0; t_a = '0; t_d = '0;
      for (int k = 0; k < 8; k++) mmem[k] = '0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          n = 0; start = -100; exp_rd = '0;
          for (int k = 0; k < 8; k++) mmem[k] = '0;
        end else begin
          n = n + 1;
          if (n == start + W + 1 && !t_wr) exp_rd = mmem[t_a];
          if (n == start + W + 2 && t_wr) mmem[t_a] = t_d;
          if (!((n - 1) >= start && (n - 1) <= start + W + 1) && bus.i_sel) begin
            start = n;
            t_wr  = bus.i_write;
            t_a   = bus.i_addr;
            t_d   = bus.i_wdata;
          end
        end
      end
    end

    initial begin : cmp
      bit         in_xfer, resp;
      logic [1:0] exp_st;
      ok_cnt = 0;
      forever begin
        @(negedge clk);
        in_xfer = (n >= start) && (n <= start + W + 1);
        resp    = (n == start + W + 1);
        exp_st  = !in_xfer ? 2'b00 : (resp ? 2'b10 : 2'b01);
        check($sformatf("dut%0d o_ok", gi),    32'(bus.o_ok),    32'(resp));
        check($sformatf("dut%0d o_busy", gi),  32'(bus.o_busy),  32'(in_xfer));
        check($sformatf("dut%0d o_state", gi), 32'(bus.o_state), 32'(exp_st));
        check($sformatf("dut%0d o_rdata", gi), 32'(bus.o_rdata), 32'(exp_rd));
        if (bus.o_ok) ok_cnt++;
      end
    end
  end

  function automatic int okc(input int d);
    return (d == 0) ? g_dut[0].ok_cnt : g_dut[1].ok_cnt;
  endfunction

  // One transfer on DUT d. The caller is positioned just after a rising edge.
  // lat is the number of edges from the sampling edge to the ok cycle.
  task automatic xfer(input int d, input bit w, input logic [2:0] a, input logic [7:0] dat,
                      input bit scramble, output logic [7:0] rd, output int lat);
    int e;
    bit seen;
    act = d; sel = 1'b1; wr = w; addr = a; wdata = dat;
    @(posedge clk); #1;
    e = cyc;
    sel = 1'b0;
    if (scramble) begin addr = 3'd2; wdata = 8'hFF; end
    seen = 1'b0; lat = -1; rd = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ok_w[d]) begin seen = 1'b1; lat = cyc - e; rd = rd_w[d]; end
    end
    if (!seen) begin
      chk_cnt++;
      $display("FAIL xfer timeout dut%0d: got no ok expected ok within 40 cycles", d);
    end
    @(posedge clk); #1;
    $display("xfer dut%0d %s addr=%0d wdata=%02h rdata=%02h lat=%0d", d, w ? "WR" : "RD",
             a, dat, rd, lat);
  endtask

  // Back-to-back writes of 8'h10+addr to addresses 0..7 with i_sel held high
  task automatic b2b(input int d, input int period);
    int prev, cnt, guard, ok0;
    ok0 = okc(d);
    act = d; sel = 1'b1; wr = 1'b1; addr = 3'd0; wdata = 8'h10;
    prev = 0; cnt = 0; guard = 0;
    while (cnt < 8 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (ok_w[d]) begin
        if (cnt > 0) check($sformatf("dut%0d b2b spacing", d), 32'(cyc - prev), 32'(period));
        prev = cyc;
        cnt++;
        $display("b2b dut%0d ok #%0d at cycle %0d", d, cnt, cyc);
        if (cnt < 8) begin addr = 3'(cnt); wdata = 8'h10 + 8'(cnt); end
        else sel = 1'b0;
      end
    end
    if (cnt < 8) begin
      chk_cnt++;
      $display("FAIL b2b timeout dut%0d: got %0d oks expected 8", d, cnt);
      sel = 1'b0;
    end
    @(posedge clk); #1;
    check($sformatf("dut%0d b2b ok count", d), 32'(okc(d) - ok0), 32'd8);
  endtask

  initial begin
    logic [7:0] rd;
    int         lat, ok0;
    act = 2; sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0;

    // Reset held for 3 cycles with random inputs
    repeat (3) begin
      @(posedge clk); #1;
      sel = 1'($urandom); wr = 1'($urandom); addr = 3'($urandom); wdata = 8'($urandom);
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset ok", d),    32'(ok_w[d]),   32'd0);
      check($sformatf("dut%0d reset busy", d),  32'(busy_w[d]), 32'd0);
      check($sformatf("dut%0d reset state", d), 32'(st_w[d]),   32'd0);
      check($sformatf("dut%0d reset rdata", d), 32'(rd_w[d]),   32'd0);
    end
    sel = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Every address reads zero after reset
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 8; a++) begin
        xfer(d, 1'b0, 3'(a), 8'h00, 1'b0, rd, lat);
        check($sformatf("dut%0d post-reset read %0d", d, a), 32'(rd), 32'd0);
      end

    // Write then read, WAIT_CYCLES=2
    xfer(0, 1'b1, 3'd3, 8'hA5, 1'b0, rd, lat);
    check("dut0 write latency", 32'(lat), 32'd3);
    xfer(0, 1'b0, 3'd3, 8'h00, 1'b0, rd, lat);
    check("dut0 read addr3", 32'(rd), 32'hA5);
    check("dut0 read latency", 32'(lat), 32'd3);
    xfer(0, 1'b0, 3'd4, 8'h00, 1'b0, rd, lat);
    check("dut0 read addr4", 32'(rd), 32'h00);

    // Inputs changed and i_sel dropped mid-transfer
    xfer(0, 1'b1, 3'd1, 8'h3C, 1'b1, rd, lat);
    check("dut0 scrambled write latency", 32'(lat), 32'd3);
    xfer(0, 1'b0, 3'd1, 8'h00, 1'b0, rd, lat);
    check("dut0 mem1 after scramble", 32'(rd), 32'h3C);
    xfer(0, 1'b0, 3'd2, 8'h00, 1'b0, rd, lat);
    check("dut0 mem2 after scramble", 32'(rd), 32'h00);

    // Back-to-back writes, period WAIT_CYCLES+3 = 5
    b2b(0, 5);
    for (int a = 0; a < 8; a++) begin
      xfer(0, 1'b0, 3'(a), 8'h00, 1'b0, rd, lat);
      check($sformatf("dut0 b2b readback %0d", a), 32'(rd), 32'h10 + 32'(a));
    end

    // Reset during WAIT discards the pending write
    ok0 = okc(0);
    act = 0; sel = 1'b1; wr = 1'b1; addr = 3'd5; wdata = 8'h77;
    @(posedge clk); #1;
    sel = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("dut0 async reset ok", 32'(ok_w[0]), 32'd0);
    check("dut0 async reset state", 32'(st_w[0]), 32'd0);
    check("dut0 async reset busy", 32'(busy_w[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("dut0 no ok after reset", 32'(okc(0) - ok0), 32'd0);
    $display("reset mid-transfer dut0 done");
    xfer(0, 1'b0, 3'd5, 8'h00, 1'b0, rd, lat);
    check("dut0 addr5 after reset", 32'(rd), 32'h00);

    // WAIT_CYCLES=0 instance
    xfer(1, 1'b1, 3'd7, 8'h5A, 1'b0, rd, lat);
    check("dut1 write latency", 32'(lat), 32'd1);
    xfer(1, 1'b0, 3'd7, 8'h00, 1'b0, rd, lat);
    check("dut1 read addr7", 32'(rd), 32'h5A);
    check("dut1 read latency", 32'(lat), 32'd1);
    b2b(1, 3);
    for (int a = 0; a < 8; a++) begin
      xfer(1, 1'b0, 3'(a), 8'h00, 1'b0, rd, lat);
      check($sformatf("dut1 b2b readback %0d", a), 32'(rd), 32'h10 + 32'(a));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_slave_responder.md
# bus_slave_responder

Target-side responder for the team's simple select/write/ok bus: the counterpart to the bus controller FSM, which drives i_sel/i_write and waits in its delay state for ok. The block decodes a transfer request and inserts a fixed number of wait states. It then returns a one-cycle ok pulse, with read data for reads, and commits writes to a small internal register file. It sits on the target end of the bus, behind address decode.

## Interface

Parameters
- ADDR_W, 3, address width; register file depth is 2**ADDR_W.
- DATA_W, 8, data width.
- WAIT_CYCLES, 2, extra wait states before ok; legal range 0..15.

Ports
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- i_sel  input  1  transfer request from the initiator.
- i_write  input  1  1 = write, 0 = read; sampled with i_sel.
- i_addr  input  ADDR_W  register index; sampled with i_sel.
- i_wdata  input  DATA_W  write data; sampled with i_sel.
- o_ok  output  1  transfer-complete pulse, one cycle wide.
- o_rdata  output  DATA_W  read data; valid while o_ok is high on a read.
- o_busy  output  1  high whenever the state is not IDLE.
- o_state  output  2  current state encoding, for debug.

## Operation

- States and encodings:
  - IDLE = 2'b00
  - WAIT = 2'b01
  - RESP = 2'b10
  - 2'b11 is illegal and returns to IDLE on the next edge.
- IDLE:
  - i_sel=1 at an edge latches i_write, i_addr and i_wdata into internal registers, loads the wait counter with WAIT_CYCLES, and moves to WAIT.
  - i_sel=0 stays in IDLE.
- WAIT:
  - counter != 0: decrement and stay in WAIT.
  - counter == 0: move to RESP.
  - On entry to RESP for a read, o_rdata loads mem[latched addr].
- RESP:
  - o_ok=1.
  - A write updates mem[latched addr] with the latched data on the RESP->IDLE edge.
  - The next state is always IDLE.
- Once a transfer starts, it always completes. i_sel, i_write, i_addr and i_wdata are ignored outside IDLE; de-asserting i_sel mid-transfer does not abort it.
- o_rdata holds its last read value until the next read response; writes do not change it.
- Outputs are Moore decodes of state:
  - o_ok = (state == RESP)
  - o_busy = (state != IDLE)
- The wait counter is 4 bits and never underflows, because a zero count exits WAIT.
- There is no address error; every address in 0..2**ADDR_W-1 is valid.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - state = IDLE, o_ok = 0, o_busy = 0, o_state = 2'b00
  - o_rdata = 0, all register file entries = 0, wait counter = 0
- Latency, with edge E the edge at which i_sel=1 is sampled in IDLE:
  - WAIT occupies the cycles after edges E .. E+WAIT_CYCLES (WAIT_CYCLES+1 cycles).
  - o_ok is high for exactly one cycle, the cycle after edge E+WAIT_CYCLES+1.
  - A write is visible in memory after edge E+WAIT_CYCLES+2.
- Minimum transfer period: WAIT_CYCLES+3 cycles. If i_sel is still high when the block is back in IDLE, a new transfer starts at that edge (back-to-back); the initiator must drop i_sel after ok to avoid a repeat.
- Read after write to the same address: the earliest read to start after the write's RESP returns the new data.
- Reset during WAIT or RESP: return to IDLE immediately, o_ok drops asynchronously, a pending write is discarded, and memory is cleared.

## Test plan

- Reset values: hold i_rst_n=0 for 3 cycles with random inputs -> o_ok=0, o_busy=0, o_state=00, o_rdata=0. A read of every address after reset returns 0.
- Write then read, WAIT_CYCLES=2:
  - Write addr 3, data 8'hA5, with i_sel sampled at edge E -> o_ok high only in the cycle after E+3.
  - Read addr 3 -> o_rdata=8'hA5 while o_ok=1.
  - A read of addr 4 returns 8'h00.
- Mid-transfer input changes: start a write to addr 1 with 8'h3C, then during WAIT change i_addr to 2, i_wdata to 8'hFF and drop i_sel -> transfer completes, mem[1]=8'h3C, mem[2]=8'h00.
- Back-to-back: hold i_sel=1 with alternating writes to addrs 0..7 (data 8'h10+addr) -> one o_ok per transfer, spaced WAIT_CYCLES+3 cycles apart. Read-back of all eight addresses matches.
- Reset mid-operation: write 8'h77 to addr 5, assert i_rst_n=0 during WAIT -> o_ok never pulses, and a subsequent read of addr 5 returns 8'h00.
- WAIT_CYCLES=0 build: i_sel sampled at edge E -> o_ok in the cycle after E+1, a 3-cycle period. Repeat the write/read check with addr 7, data 8'h5A.
